// File: rtl/fft_r2sdf_bf_stage_if.sv
// Sample stream bundle for one R2SDF butterfly stage: input beat, output beat, twiddle tag.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides; ready_o is the stage's upstream ready.
interface fft_r2sdf_bf_stage_if #(
    parameter int D = 4,
    parameter int W = 16
);
    localparam int KW = $clog2(D);

    logic              valid_i;
    logic [2*W-1:0]    data_i;
    logic              ready_o;
    logic              valid_o;
    logic [2*W-1:0]    data_o;
    logic              diff_o;
    logic [KW-1:0]     tw_idx_o;
    logic              ready_i;

    // Stage side: consumes samples, produces butterfly outputs.
    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, diff_o, tw_idx_o
    );

    // Environment side: feeds samples and takes outputs.
    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, diff_o, tw_idx_o
    );
endinterface

// File: rtl/fft_r2sdf_bf_stage.sv
// Radix-2 SDF DIF butterfly stage: sums out immediately, differences one half-frame later (FFT_BF_SCALE_EN: halve results).
// Latency: one register stage from accept to output.
// Backpressure: ready_o = ready_i | ~valid_o; a stalled output freezes counter, delay line and output register.
module fft_r2sdf_bf_stage #(
    parameter int D = 4,
    parameter int W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    fft_r2sdf_bf_stage_if.slave  bus
);
    localparam int KW = $clog2(D);
    localparam int CW = KW + 1;

    logic [CW-1:0]   cnt_q;
    logic            primed_q;
    logic [2*W-1:0]  dl [D];

    logic            en;
    logic            acc;
    logic            phase;
    logic [KW-1:0]   k;
    logic [2*W-1:0]  a;
    logic [2*W-1:0]  x;
    logic signed [W:0] a_re, a_im, x_re, x_im;
    logic signed [W:0] s_re, s_im, d_re, d_im;
    logic [2*W-1:0]  sum_w;
    logic [2*W-1:0]  dif_w;
    logic [2*W-1:0]  dl_wdat;
    logic            emit;
    logic [2*W-1:0]  emit_dat;
    logic            emit_diff;
    logic [KW-1:0]   emit_tw;

    // Bring a W+1-bit butterfly result back to W bits.
    function automatic logic [W-1:0] reduce(input logic signed [W:0] v);
`ifdef FFT_BF_SCALE_EN
        logic signed [W:0] h;
        h = v >>> 1;
        return h[W-1:0];
`else
        if (v[W] != v[W-1])
            return v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            return v[W-1:0];
`endif
    endfunction

    assign en          = bus.ready_i | ~bus.valid_o;
    assign bus.ready_o = en;
    assign acc         = bus.valid_i & en;
    assign phase       = cnt_q[CW-1];
    assign k           = cnt_q[KW-1:0];
    assign a           = dl[k];
    assign x           = bus.data_i;

    // Per-component butterfly at W+1 bits, reduced to W bits.
    always_comb begin
        a_re  = {a[2*W-1], a[2*W-1:W]};
        a_im  = {a[W-1], a[W-1:0]};
        x_re  = {x[2*W-1], x[2*W-1:W]};
        x_im  = {x[W-1], x[W-1:0]};
        s_re  = a_re + x_re;
        s_im  = a_im + x_im;
        d_re  = a_re - x_re;
        d_im  = a_im - x_im;
        sum_w = {reduce(s_re), reduce(s_im)};
        dif_w = {reduce(d_re), reduce(d_im)};
    end

    // Phase 0 stores the new sample and drains last frame's difference; phase 1 pairs and stores the difference.
    always_comb begin
        dl_wdat   = x;
        emit      = 1'b0;
        emit_dat  = '0;
        emit_diff = 1'b0;
        emit_tw   = '0;
        if (!phase) begin
            dl_wdat   = x;
            emit      = primed_q;
            emit_dat  = a;
            emit_diff = 1'b1;
            emit_tw   = k;
        end else begin
            dl_wdat   = dif_w;
            emit      = 1'b1;
            emit_dat  = sum_w;
            emit_diff = 1'b0;
            emit_tw   = '0;
        end
    end

    // Delay line: read-before-write on each accept; contents need no reset since they are rewritten before use.
    always_ff @(posedge clk_i) begin
        if (acc)
            dl[k] <= dl_wdat;
    end

    // Sample counter and priming flag; the counter wraps naturally at 2D.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            primed_q <= 1'b0;
        end else if (acc) begin
            cnt_q <= cnt_q + 1'b1;
            if (&cnt_q)
                primed_q <= 1'b1;
        end
    end

    // Output register: load on an emitting accept, otherwise drain when downstream takes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.valid_o  <= 1'b0;
            bus.data_o   <= '0;
            bus.diff_o   <= 1'b0;
            bus.tw_idx_o <= '0;
        end else if (acc && emit) begin
            bus.valid_o  <= 1'b1;
            bus.data_o   <= emit_dat;
            bus.diff_o   <= emit_diff;
            bus.tw_idx_o <= emit_tw;
        end else if (bus.ready_i) begin
            bus.valid_o  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fft_r2sdf_bf_stage.sv
// Self-checking bench for fft_r2sdf_bf_stage with a reference model feeding an expected-output queue.
// Latency: outputs checked when taken by the bench acting as downstream.
// Backpressure: bench drives ready_i, including a deliberate stall.
module tb_fft_r2sdf_bf_stage;
    localparam int D  = 4;
    localparam int W  = 16;
    localparam int KW = $clog2(D);
    localparam int IW = 2*W + 1 + KW;

    typedef logic [IW-1:0] item_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;

    fft_r2sdf_bf_stage_if #(.D(D), .W(W)) bus ();

    fft_r2sdf_bf_stage #(.D(D), .W(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    item_t sb[$];
    item_t obs[$];
    bit    rec = 1'b0;

    int    m_cnt = 0;
    bit    m_primed = 1'b0;
    int    m_re [D];
    int    m_im [D];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int red(input int v);
`ifdef FFT_BF_SCALE_EN
        return v >>> 1;
`else
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
`endif
    endfunction

    function automatic item_t mk(input int re, input int im, input bit d, input int tw);
        logic [W-1:0]  r;
        logic [W-1:0]  i;
        logic [KW-1:0] t;
        r = W'(re);
        i = W'(im);
        t = KW'(tw);
        return {r, i, d, t};
    endfunction

    task automatic model_accept(input logic [2*W-1:0] din);
        int k;
        int xr;
        int xi;
        k  = m_cnt % D;
        xr = int'($signed(din[2*W-1:W]));
        xi = int'($signed(din[W-1:0]));
        if (m_cnt < D) begin
            if (m_primed)
                sb.push_back(mk(m_re[k], m_im[k], 1'b1, k));
            m_re[k] = xr;
            m_im[k] = xi;
        end else begin
            sb.push_back(mk(red(m_re[k] + xr), red(m_im[k] + xi), 1'b0, 0));
            m_re[k] = red(m_re[k] - xr);
            m_im[k] = red(m_im[k] - xi);
        end
        if (m_cnt == 2*D-1)
            m_primed = 1'b1;
        m_cnt = (m_cnt + 1) % (2*D);
    endtask

    // Monitor: compare taken outputs against the queue, then advance the model on accepts.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (bus.valid_o && bus.ready_i) begin
                if (sb.size() == 0)
                    check("unexpected_out", {bus.data_o, bus.diff_o, bus.tw_idx_o}, 64'hdead);
                else
                    check("out", {bus.data_o, bus.diff_o, bus.tw_idx_o}, sb.pop_front());
                if (rec)
                    obs.push_back({bus.data_o, bus.diff_o, bus.tw_idx_o});
            end
            if (bus.valid_i && bus.ready_o)
                model_accept(bus.data_i);
        end
    end

    task automatic send(input int re, input int im);
        int guard;
        guard = 0;
        bus.valid_i = 1'b1;
        bus.data_i  = {W'(re), W'(im)};
        @(negedge clk);
        while (!bus.ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.ready_o)
            check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.ready_i = 1'b1;
        #1;
        sb.delete();
        obs.delete();
        m_cnt    = 0;
        m_primed = 1'b0;
        check("rst_valid_o", bus.valid_o, 0);
        check("rst_data_o", bus.data_o, 0);
        check("rst_diff_o", bus.diff_o, 0);
        check("rst_tw_idx_o", bus.tw_idx_o, 0);
        check("rst_ready_o", bus.ready_o, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic wait_obs(input int n);
        int guard;
        guard = 0;
        while (obs.size() < n && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (obs.size() < n)
            check("obs_timeout", obs.size(), n);
    endtask

    // Frame 1..8 then a zero frame; checks the hand-derived outputs.
    task automatic ramp_test(input string tag);
        obs.delete();
        rec = 1'b1;
        for (int i = 1; i <= D; i++)
            send(i, 0);
        check({tag, "_unprimed_valid"}, bus.valid_o, 0);
        for (int i = D+1; i <= 2*D; i++)
            send(i, 0);
        for (int i = 0; i < 2*D; i++)
            send(0, 0);
        wait_obs(2*D);
        rec = 1'b0;
        if (obs.size() >= 2*D) begin
            for (int i = 0; i < D; i++)
                check({tag, "_sum"}, obs[i], mk(6 + 2*i, 0, 1'b0, 0));
            for (int i = 0; i < D; i++)
                check({tag, "_diff"}, obs[D+i], mk(-4, 0, 1'b1, i));
        end
    endtask

    initial begin
        logic [2*W-1:0] held;
        int guard;

        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.ready_i = 1'b1;
        do_reset();
        @(posedge clk);
        #1;

        ramp_test("ramp");

        // Saturation / scaling corner cases at k=0 (sum) and k=1 (difference).
        do_reset();
        @(posedge clk);
        #1;
        obs.delete();
        rec = 1'b1;
        send(32767, 0); send(-32768, 0); send(0, 0); send(0, 0);
        send(32767, 0); send(32767, 0);  send(0, 0); send(0, 0);
        for (int i = 0; i < 2*D; i++)
            send(0, 0);
        wait_obs(2*D);
        rec = 1'b0;
        if (obs.size() >= 2*D) begin
            check("sat_sum", obs[0], mk(32767, 0, 1'b0, 0));
            check("sat_diff", obs[D+1], mk(-32768, 0, 1'b1, 1));
        end

        // Mid-frame reset at cnt=5, then the ramp must behave as from a clean start.
        for (int i = 0; i < 5; i++)
            send(i + 3, i);
        do_reset();
        @(posedge clk);
        #1;
        ramp_test("post_rst");

        // Random full-rate frames with one three-cycle downstream stall.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 2*D; i++) begin
                if (f == 1 && i == 6) begin
                    bus.ready_i = 1'b0;
                    bus.valid_i = 1'b1;
                    bus.data_i  = 32'h1234_5678;
                    @(negedge clk);
                    held = bus.data_o;
                    check("stall_valid_o", bus.valid_o, 1);
                    for (int c = 0; c < 3; c++) begin
                        check("stall_ready_o", bus.ready_o, 0);
                        check("stall_data_o", bus.data_o, held);
                        @(negedge clk);
                    end
                    @(posedge clk);
                    #1;
                    bus.ready_i = 1'b1;
                    send(32'sh1234, 32'sh5678);
                end else begin
                    send(int'($signed(16'($urandom))), int'($signed(16'($urandom))));
                end
            end
        end
        for (int i = 0; i < 2*D; i++)
            send(0, 0);

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
